// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants, types and helpers for the
// one-hot decode/encode blocks.
package decoder_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = $clog2(DEF_N);

    // Widest code the shared helper handles; narrower codes are zero-extended.
    localparam int MAX_N = 64;
    localparam int MAX_W = $clog2(MAX_N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    typedef struct packed {
        logic             err;
        logic [MAX_W-1:0] idx;
    } enc_t;

    // Lowest set bit wins; err flags zero-hot and multi-hot codes.
    function automatic enc_t onehot_to_idx(input logic [MAX_N-1:0] d);
        enc_t        r;
        int unsigned ones;
        r    = '0;
        ones = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (d[i]) begin
                r.idx = i[MAX_W-1:0];
                ones++;
            end
        end
        r.err = (ones != 1);
        return r;
    endfunction

endpackage

// File: rtl/onehot_encoder_pipe_if.sv
// onehot_encoder_pipe_if: input code stream and encoded
// result stream, each with a valid/ready handshake.
interface onehot_encoder_pipe_if
    import decoder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = $clog2(N)
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_d;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic         out_err;

    modport master (
        output in_valid,
        output in_d,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_a,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_d,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_a,
        output out_err
    );

endinterface

// File: rtl/onehot_encoder_pipe_prio_enc.sv
// onehot_prio_enc: combinational lowest-set-bit encoder
// with zero-hot and multi-hot detection.
module onehot_prio_enc
    import decoder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] d,
    output logic [W-1:0] idx,
    output logic         zero,
    output logic         multi
);

    logic [MAX_N-1:0] d_ext;
    enc_t             enc;

    always_comb begin
        d_ext        = '0;
        d_ext[N-1:0] = d;
    end

    assign enc   = onehot_to_idx(d_ext);
    assign idx   = enc.idx[W-1:0];
    assign zero  = ~|d;
    assign multi = enc.err & ~zero;

    // Upper index bits are always zero for codes narrower than MAX_N.
    generate
        if (W < MAX_W) begin : g_hi
            logic unused_idx_hi;
            assign unused_idx_hi = ^enc.idx[MAX_W-1:W];
        end
    endgenerate

endmodule

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: one-hot to binary index encoder with a
// single registered output slot and error statistics.
module onehot_encoder_pipe
    import decoder_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_encoder_pipe_if.slave bus,
    input  logic                 err_clr,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_e            state;
    logic [W-1:0]     a_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;

    logic [W-1:0]     enc_idx;
    logic             enc_zero;
    logic             enc_multi;
    logic             enc_err;
    logic             accept;
    logic             acc_err;

    onehot_prio_enc #(
        .N (N),
        .W (W)
    ) u_enc (
        .d     (bus.in_d),
        .idx   (enc_idx),
        .zero  (enc_zero),
        .multi (enc_multi)
    );

    assign enc_err      = enc_zero | enc_multi;
    assign bus.in_ready = (state == EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign acc_err      = accept && enc_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            a_q   <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                        a_q   <= enc_idx;
                        err_q <= enc_err;
                    end
                end
                FULL: begin
                    if (accept) begin
                        a_q   <= enc_idx;
                        err_q <= enc_err;
                    end else if (bus.out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Clear beats the count, but an error in the clear cycle stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            priority case (1'b1)
                err_clr: begin
                    cnt_q    <= '0;
                    sticky_q <= acc_err;
                end
                acc_err: begin
                    sticky_q <= 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_a     = a_q;
    assign bus.out_err   = err_q;
    assign err_sticky    = sticky_q;
    assign err_cnt       = cnt_q;

endmodule
